// File: rtl/uart_pkt_pkg.sv
// Shared state encoding, sync-byte default and checksum helper for the
// UART packet receiver.
package uart_pkt_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ADDR    = 3'd1,
      LEN     = 3'd2,
      PAYLOAD = 3'd3,
      CHK     = 3'd4,
      DRAIN   = 3'd5
   } pkt_state_e;

   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

   // A frame is good when ADDR+LEN+payload+CHK wraps to zero.
   function automatic logic chk_ok(input logic [7:0] sum, input logic [7:0] chk);
      logic [7:0] total;
      total = sum + chk;
      return (total == 8'h00);
   endfunction

endpackage

// File: rtl/uart_pkt_buf.sv
// Payload store: DEPTH x 8, one synchronous write port, one asynchronous
// read port (maps onto distributed RAM).
module uart_pkt_buf #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 4
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic [AW-1:0] raddr,
   output logic [7:0]    rdata
);

   logic [7:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_rx_pkt_ctrl.sv
// Frames the uart_rx byte stream (SYNC ADDR LEN payload CHK) and releases
// checked payload on a valid/ready stream. Inter-byte timeout: UART_RX_PKT_TIMEOUT_EN.
module uart_rx_pkt_ctrl
   import uart_pkt_pkg::*;
#(
   parameter int unsigned MAXLEN    = 16,
   parameter int unsigned TIMEOUT   = 1024,
   parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_recv,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_data,
   output logic [7:0] out_addr,
   output logic       out_last,
   output logic       frame_ok,
   output logic       err_chk,
   output logic       err_len,
   output logic       err_timeout,
   output logic       err_overrun
);

   localparam int unsigned PW = $clog2(MAXLEN + 1);
   localparam int unsigned BW = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;
   localparam logic [PW-1:0] PTR_ZERO = PW'(0);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);

   if ((MAXLEN < 1) || (MAXLEN > 255)) begin : g_bad_maxlen
      $error("uart_rx_pkt_ctrl: MAXLEN must be in 1..255");
   end
   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("uart_rx_pkt_ctrl: TIMEOUT must be at least 1");
   end

   pkt_state_e    state_q, state_d;
   logic [7:0]    addr_q, addr_d;
   logic [7:0]    sum_q, sum_d;
   logic [PW-1:0] len_q, len_d;
   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic          ok_q, ok_d;
   logic          chk_err_q, chk_err_d;
   logic          len_err_q, len_err_d;
   logic          ovr_q, ovr_d;
   logic          buf_we;
   logic [7:0]    buf_rdata;
   logic          drain_s;
   logic          last_s;
   logic          timeout_hit;

   uart_pkt_buf #(
      .DEPTH (MAXLEN),
      .AW    (BW)
   ) u_buf (
      .clk   (clk),
      .we    (buf_we),
      .waddr (wptr_q[BW-1:0]),
      .wdata (rx_data),
      .raddr (rptr_q[BW-1:0]),
      .rdata (buf_rdata)
   );

   assign drain_s = (state_q == DRAIN);
   assign last_s  = (rptr_q == (len_q - PTR_ONE));

`ifdef UART_RX_PKT_TIMEOUT_EN
   localparam int unsigned GW = $clog2(TIMEOUT + 1);

   logic [GW-1:0] gap_q, gap_d;
   logic          in_frame;
   logic          to_q;

   // Gap counter only runs while a frame is being collected.
   always_comb begin
      in_frame    = (state_q == ADDR) || (state_q == LEN) ||
                    (state_q == PAYLOAD) || (state_q == CHK);
      timeout_hit = 1'b0;
      gap_d       = GW'(0);
      if (!in_frame || rx_recv) begin
         gap_d = GW'(0);
      end else if (gap_q == GW'(TIMEOUT - 1)) begin
         timeout_hit = 1'b1;
         gap_d       = GW'(0);
      end else begin
         gap_d = gap_q + GW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gap_q <= GW'(0);
         to_q  <= 1'b0;
      end else begin
         gap_q <= gap_d;
         to_q  <= timeout_hit;
      end
   end

   assign err_timeout = to_q;
`else
   assign timeout_hit = 1'b0;
   assign err_timeout = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      sum_d     = sum_q;
      len_d     = len_q;
      wptr_d    = wptr_q;
      rptr_d    = rptr_q;
      buf_we    = 1'b0;
      ok_d      = 1'b0;
      chk_err_d = 1'b0;
      len_err_d = 1'b0;
      ovr_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (rx_recv && (rx_data == SYNC_BYTE)) begin
               state_d = ADDR;
            end else begin
               state_d = IDLE;
            end
         end
         ADDR: begin
            if (rx_recv) begin
               addr_d  = rx_data;
               sum_d   = rx_data;
               state_d = LEN;
            end else begin
               state_d = ADDR;
            end
         end
         LEN: begin
            if (rx_recv) begin
               sum_d  = sum_q + rx_data;
               wptr_d = PTR_ZERO;
               if (rx_data > 8'(MAXLEN)) begin
                  len_err_d = 1'b1;
                  state_d   = IDLE;
               end else if (rx_data == 8'h00) begin
                  len_d   = PTR_ZERO;
                  state_d = CHK;
               end else begin
                  len_d   = rx_data[PW-1:0];
                  state_d = PAYLOAD;
               end
            end else begin
               state_d = LEN;
            end
         end
         PAYLOAD: begin
            if (rx_recv) begin
               buf_we = 1'b1;
               sum_d  = sum_q + rx_data;
               wptr_d = wptr_q + PTR_ONE;
               if (wptr_d == len_q) begin
                  state_d = CHK;
               end else begin
                  state_d = PAYLOAD;
               end
            end else begin
               state_d = PAYLOAD;
            end
         end
         CHK: begin
            if (rx_recv) begin
               if (chk_ok(sum_q, rx_data)) begin
                  ok_d    = 1'b1;
                  rptr_d  = PTR_ZERO;
                  state_d = (len_q == PTR_ZERO) ? IDLE : DRAIN;
               end else begin
                  chk_err_d = 1'b1;
                  state_d   = IDLE;
               end
            end else begin
               state_d = CHK;
            end
         end
         DRAIN: begin
            // Nothing is parsed while draining; every arriving byte is lost.
            ovr_d = rx_recv;
            if (out_ready) begin
               rptr_d  = rptr_q + PTR_ONE;
               state_d = last_s ? IDLE : DRAIN;
            end else begin
               state_d = DRAIN;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      state_d = timeout_hit ? IDLE : state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         addr_q    <= 8'h00;
         sum_q     <= 8'h00;
         len_q     <= PTR_ZERO;
         wptr_q    <= PTR_ZERO;
         rptr_q    <= PTR_ZERO;
         ok_q      <= 1'b0;
         chk_err_q <= 1'b0;
         len_err_q <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         sum_q     <= sum_d;
         len_q     <= len_d;
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         ok_q      <= ok_d;
         chk_err_q <= chk_err_d;
         len_err_q <= len_err_d;
         ovr_q     <= ovr_d;
      end
   end

   assign out_valid   = drain_s;
   assign out_data    = drain_s ? buf_rdata : 8'h00;
   assign out_addr    = addr_q;
   assign out_last    = drain_s && last_s;
   assign frame_ok    = ok_q;
   assign err_chk     = chk_err_q;
   assign err_len     = len_err_q;
   assign err_overrun = ovr_q;

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Self-checking bench: queue-based frame parser model compared every cycle,
// directed frames with literal expectations, then randomized traffic.
module tb_uart_rx_pkt_ctrl;

   localparam int MAXLEN  = 16;
   localparam int TIMEOUT = 1024;
   localparam logic [7:0] SYNC = 8'hA5;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_recv;
   logic       out_ready;
   logic       out_valid;
   logic [7:0] out_data;
   logic [7:0] out_addr;
   logic       out_last;
   logic       frame_ok;
   logic       err_chk;
   logic       err_len;
   logic       err_timeout;
   logic       err_overrun;

   int rdy_mode = 1;
   int n_vec = 0;
   int n_err = 0;

   uart_rx_pkt_ctrl #(
      .MAXLEN    (MAXLEN),
      .TIMEOUT   (TIMEOUT),
      .SYNC_BYTE (SYNC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rx_data     (rx_data),
      .rx_recv     (rx_recv),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_addr    (out_addr),
      .out_last    (out_last),
      .frame_ok    (frame_ok),
      .err_chk     (err_chk),
      .err_len     (err_len),
      .err_timeout (err_timeout),
      .err_overrun (err_overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: collect bytes of the current frame in a queue and judge
   // the frame once its length is known; accepted payload goes to outq.
   logic [7:0] frm[$];
   logic [7:0] outq[$];
   logic [7:0] m_addr = 8'h00;
   int         gap = 0;
   int         msum;
   logic       was_drain;
   logic       e_ok = 1'b0, e_chk = 1'b0, e_len = 1'b0, e_ovr = 1'b0, e_to = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         frm.delete();
         outq.delete();
         gap = 0;
         m_addr = 8'h00;
         e_ok = 1'b0; e_chk = 1'b0; e_len = 1'b0; e_ovr = 1'b0; e_to = 1'b0;
      end else begin
         was_drain = (outq.size() > 0);
         e_ok = 1'b0; e_chk = 1'b0; e_len = 1'b0; e_ovr = 1'b0; e_to = 1'b0;
         if (rx_recv) begin
            gap = 0;
            if (was_drain) begin
               e_ovr = 1'b1;
            end else if (frm.size() == 0) begin
               if (rx_data == SYNC) frm.push_back(rx_data);
            end else begin
               frm.push_back(rx_data);
               if (frm.size() == 3) begin
                  if (int'(frm[2]) > MAXLEN) begin
                     e_len = 1'b1;
                     frm.delete();
                  end
               end else if (frm.size() == 4 + int'(frm[2])) begin
                  msum = 0;
                  for (int i = 1; i < frm.size(); i++) msum += int'(frm[i]);
                  if ((msum % 256) == 0) begin
                     e_ok = 1'b1;
                     m_addr = frm[1];
                     for (int i = 0; i < int'(frm[2]); i++) outq.push_back(frm[3 + i]);
                  end else begin
                     e_chk = 1'b1;
                  end
                  frm.delete();
               end
            end
         end else begin
`ifdef UART_RX_PKT_TIMEOUT_EN
            if (frm.size() > 0) begin
               gap++;
               if (gap == TIMEOUT) begin
                  e_to = 1'b1;
                  frm.delete();
                  gap = 0;
               end
            end
`endif
         end
         if (was_drain && out_ready) void'(outq.pop_front());
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      check("out_valid", out_valid, outq.size() > 0);
      if (outq.size() > 0) begin
         check("out_data", out_data, outq[0]);
         check("out_last", out_last, outq.size() == 1);
         check("out_addr", out_addr, m_addr);
      end else begin
         check("out_last_idle", out_last, 1'b0);
      end
      check("frame_ok", frame_ok, e_ok);
      check("err_chk", err_chk, e_chk);
      check("err_len", err_len, e_len);
      check("err_overrun", err_overrun, e_ovr);
      check("err_timeout", err_timeout, e_to);
   end

   // Observation counters for the directed literal checks.
   int c_ok = 0, c_chk = 0, c_len = 0, c_ovr = 0, c_to = 0, c_valid = 0;
   logic [7:0] got[$];
   logic [7:0] got_addr = 8'h00;
   logic [7:0] got_last = 8'h00;

   always @(negedge clk) begin
      if (frame_ok) c_ok++;
      if (err_chk) c_chk++;
      if (err_len) c_len++;
      if (err_overrun) c_ovr++;
      if (err_timeout) c_to++;
      if (out_valid) c_valid++;
      if (out_valid && out_ready) begin
         got.push_back(out_data);
         got_addr = out_addr;
         if (out_last) got_last = out_data;
      end
   end

   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (rdy_mode == 0) out_ready = 1'($urandom_range(0, 1));
         else out_ready = (rdy_mode == 1);
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [7:0] b);
      rx_data = b;
      rx_recv = 1'b1;
      @(posedge clk);
      #1;
      rx_recv = 1'b0;
      rx_data = 8'h00;
   endtask

   task automatic send_gap(input logic [7:0] b);
      send(b);
      tick($urandom_range(0, 2));
   endtask

   task automatic wait_drain(input string name);
      int k;
      k = 0;
      while (out_valid && k < 400) begin
         tick(1);
         k++;
      end
      check(name, out_valid, 1'b0);
   endtask

   task automatic send_good();
      send(8'hA5); send(8'h03); send(8'h02); send(8'h10); send(8'h20); send(8'hCB);
   endtask

   task automatic check_got_10_20(input string name);
      check({name, "_cnt"}, got.size(), 2);
      if (got.size() == 2) begin
         check({name, "_b0"}, got[0], 8'h10);
         check({name, "_b1"}, got[1], 8'h20);
      end
      check({name, "_addr"}, got_addr, 8'h03);
      check({name, "_last"}, got_last, 8'h20);
   endtask

   int b_ok, b_chk, b_len, b_ovr, b_to, b_valid;
   int kind, len;
   logic [7:0] a, s, c, g;
   logic [7:0] pl[$];

   initial begin
      rst = 1'b1;
      rx_recv = 1'b0;
      rx_data = 8'h00;
      tick(2);
      check("rst_valid", out_valid, 1'b0);
      check("rst_data", out_data, 8'h00);
      check("rst_addr", out_addr, 8'h00);
      check("rst_last", out_last, 1'b0);
      check("rst_errs", {frame_ok, err_chk, err_len, err_overrun, err_timeout}, 5'b0);
      rst = 1'b0;
      tick(2);

      // Good frame, consumer always ready.
      got.delete(); got_last = 8'h00; b_ok = c_ok;
      send_good();
      wait_drain("good_drain");
      tick(1);
      check("good_ok", c_ok - b_ok, 1);
      check_got_10_20("good");

      // Checksum off by one.
      b_chk = c_chk; b_valid = c_valid;
      send(8'hA5); send(8'h03); send(8'h02); send(8'h10); send(8'h20); send(8'hCC);
      tick(3);
      check("badchk_pulse", c_chk - b_chk, 1);
      check("badchk_novalid", c_valid - b_valid, 0);

      // Over-length, then an empty frame.
      b_len = c_len;
      send(8'hA5); send(8'h01); send(8'h11);
      tick(2);
      check("overlen_pulse", c_len - b_len, 1);
      got.delete(); b_ok = c_ok; b_valid = c_valid;
      send(8'hA5); send(8'h01); send(8'h00); send(8'hFF);
      tick(3);
      check("empty_ok", c_ok - b_ok, 1);
      check("empty_nobytes", got.size(), 0);
      check("empty_novalid", c_valid - b_valid, 0);

      // Backpressure and overrun.
      rdy_mode = 2;
      tick(1);
      got.delete(); got_last = 8'h00; b_ovr = c_ovr;
      send_good();
      tick(2);
      send(8'h55);
      tick(1);
      check("ovr_pulse", c_ovr - b_ovr, 1);
      check("ovr_hold_valid", out_valid, 1'b1);
      check("ovr_hold_data", out_data, 8'h10);
      rdy_mode = 1;
      tick(1);
      wait_drain("ovr_drain");
      tick(1);
      check_got_10_20("ovr");

`ifdef UART_RX_PKT_TIMEOUT_EN
      b_to = c_to;
      send(8'hA5); send(8'h03);
      tick(TIMEOUT + 5);
      check("timeout_pulse", c_to - b_to, 1);
      got.delete(); got_last = 8'h00; b_ok = c_ok;
      send_good();
      wait_drain("timeout_drain");
      tick(1);
      check("timeout_next_ok", c_ok - b_ok, 1);
      check_got_10_20("timeout_next");
`endif

      // Asynchronous reset in the middle of a payload.
      send(8'hA5); send(8'h03); send(8'h02); send(8'h10);
      #2;
      rst = 1'b1;
      #1;
      check("arst_valid", out_valid, 1'b0);
      check("arst_addr", out_addr, 8'h00);
      check("arst_out", {out_data, out_last}, 9'h0);
      check("arst_errs", {frame_ok, err_chk, err_len, err_overrun, err_timeout}, 5'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick(1);
      got.delete(); got_last = 8'h00; b_ok = c_ok;
      send_good();
      wait_drain("arst_drain");
      tick(1);
      check("arst_next_ok", c_ok - b_ok, 1);
      check_got_10_20("arst_next");

      // Randomized traffic with random consumer stalls.
      rdy_mode = 0;
      for (int f = 0; f < 250; f++) begin
         kind = $urandom_range(0, 9);
         a = 8'($urandom_range(0, 255));
         if (kind <= 5) begin
            len = $urandom_range(0, MAXLEN);
            pl.delete();
            s = a + 8'(len);
            for (int i = 0; i < len; i++) begin
               pl.push_back(8'($urandom_range(0, 255)));
               s = s + pl[i];
            end
            c = 8'h00 - s;
            if (kind == 5) c = c ^ (8'h01 << $urandom_range(0, 7));
            send_gap(SYNC); send_gap(a); send_gap(8'(len));
            for (int i = 0; i < len; i++) send_gap(pl[i]);
            send_gap(c);
         end else if (kind == 6) begin
            send_gap(SYNC); send_gap(a); send_gap(8'($urandom_range(MAXLEN + 1, 255)));
         end else if (kind == 7) begin
            g = 8'($urandom_range(0, 255));
            if (g == SYNC) g = 8'h5A;
            send_gap(g);
         end else begin
            tick($urandom_range(5, 40));
         end
      end
      rdy_mode = 1;
      tick(2);
      wait_drain("rand_drain");
      tick(2);

`ifndef UART_RX_PKT_TIMEOUT_EN
      check("no_timeout", c_to, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
